// File: rtl/uart_receive.sv
// uart_receive: 8N1 serial receiver feeding the RX FIFO.
// Recovers idle-high frames (start 0, 8 data bits LSB first, stop 1) at
// div_q clocks per bit. Flags framing and overrun errors with one-cycle pulses.
// Optional feature: define UART_RX_TIMEOUT_EN to enable the idle-timeout pulse
// on rx_timeout; without it rx_timeout is tied low.
module uart_receive #(
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] clk_div,
  input  logic        rx,
  input  logic        fiforx_full,
  output logic        fiforx_w_en,
  output logic [7:0]  fiforx_w_data,
  output logic        frame_err,
  output logic        overrun_err,
  output logic        busy,
  output logic        rx_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // Misconfiguration stops elaboration instead of building a broken receiver.
  if (SYNC_STAGES < 2 || TIMEOUT_BITS < 1) begin : g_param_check
    $error("uart_receive: SYNC_STAGES must be >= 2 and TIMEOUT_BITS >= 1");
  end

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_d_q;
  logic                   rx_s;
  logic                   start_edge_s;
  logic [31:0]            div_q, div_d;
  logic [31:0]            clk_cnt_q, clk_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   w_en_q, w_en_d;
  logic [7:0]             w_data_q, w_data_d;
  logic                   frame_q, frame_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;

  assign rx_s         = sync_q[SYNC_STAGES-1];
  assign start_edge_s = rx_d_q & ~rx_s;
  assign sync_d       = {sync_q[SYNC_STAGES-2:0], rx};

  // Next-state and next-output logic for the receive FSM.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    w_en_d    = 1'b0;
    w_data_d  = w_data_q;
    frame_d   = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_s) begin
          clk_cnt_d = 32'd0;
          div_d     = clk_div;
          state_d   = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (clk_cnt_q == (div_q >> 1) - 32'd1) begin
          if (!rx_s) begin
            clk_cnt_d = 32'd0;
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end else begin
            state_d = ST_IDLE;  // glitch shorter than half a bit
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == div_q - 32'd1) begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          clk_cnt_d = 32'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == div_q - 32'd1) begin
          clk_cnt_d = 32'd0;
          if (rx_s) begin
            if (!fiforx_full) begin
              w_en_d   = 1'b1;
              w_data_d = shreg_q;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = ST_IDLE;
          end else begin
            frame_d = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 32'd1;
        end
      end
      ST_BREAK: begin
        // Hold off until the line is released so a long low is not a new start.
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = 32'd0;
        bit_idx_d = 3'd0;
        shreg_d   = 8'h00;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Synchronizer, FSM state, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {SYNC_STAGES{1'b1}};
      rx_d_q    <= 1'b1;
      state_q   <= ST_IDLE;
      div_q     <= 32'd0;
      clk_cnt_q <= 32'd0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      w_en_q    <= 1'b0;
      w_data_q  <= 8'h00;
      frame_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      rx_d_q    <= rx_s;
      state_q   <= state_d;
      div_q     <= div_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      w_en_q    <= w_en_d;
      w_data_q  <= w_data_d;
      frame_q   <= frame_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign fiforx_w_en   = w_en_q;
  assign fiforx_w_data = w_data_q;
  assign frame_err     = frame_q;
  assign overrun_err   = overrun_q;
  assign busy          = busy_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LAST = TIMEOUT_BITS - 1;

  logic        armed_q, armed_d;
  logic [31:0] to_clk_q, to_clk_d;
  logic [31:0] to_bits_q, to_bits_d;
  logic        to_pulse_q, to_pulse_d;

  // Idle timeout: count bit periods in IDLE while armed by a completed write.
  always_comb begin
    armed_d    = armed_q;
    to_clk_d   = to_clk_q;
    to_bits_d  = to_bits_q;
    to_pulse_d = 1'b0;
    if (w_en_d) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
    if (state_q == ST_IDLE && !start_edge_s && armed_q) begin
      if (to_clk_q == div_q - 32'd1) begin
        to_clk_d = 32'd0;
        if (to_bits_q == 32'(TO_LAST)) begin
          to_pulse_d = 1'b1;
          armed_d    = 1'b0;
          to_bits_d  = 32'd0;
        end else begin
          to_bits_d = to_bits_q + 32'd1;
        end
      end else begin
        to_clk_d = to_clk_q + 32'd1;
      end
    end else begin
      to_clk_d  = 32'd0;
      to_bits_d = 32'd0;
    end
  end

  // Timeout counter state and registered pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= 1'b0;
      to_clk_q   <= 32'd0;
      to_bits_q  <= 32'd0;
      to_pulse_q <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      to_clk_q   <= to_clk_d;
      to_bits_q  <= to_bits_d;
      to_pulse_q <= to_pulse_d;
    end
  end

  assign rx_timeout = to_pulse_q;
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive: frames are driven on rx, expected
// bytes go to a scoreboard queue and are compared when fiforx_w_en pulses.
module tb_uart_receive;

  logic        clk;
  logic        rst_n;
  logic [31:0] clk_div;
  logic        rx;
  logic        fiforx_full;
  logic        fiforx_w_en;
  logic [7:0]  fiforx_w_data;
  logic        frame_err;
  logic        overrun_err;
  logic        busy;
  logic        rx_timeout;

  int          num_checks = 0;
  int          num_errors = 0;
  int          cyc = 0;
  int          detect_cyc = 0;
  int          last_w_cyc = 0;
  int          last_to_cyc = 0;
  int          writes = 0;
  int          frame_cnt = 0;
  int          overrun_cnt = 0;
  int          to_cnt = 0;
  int          to_base = 0;
  int          cur_div = 16;
  logic        busy_prev = 1'b0;
  logic [7:0]  exp_q[$];

  uart_receive #(.SYNC_STAGES(2), .TIMEOUT_BITS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_div       (clk_div),
    .rx            (rx),
    .fiforx_full   (fiforx_full),
    .fiforx_w_en   (fiforx_w_en),
    .fiforx_w_data (fiforx_w_data),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err),
    .busy          (busy),
    .rx_timeout    (rx_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int stop_lat(input int div);
    return (div >> 1) + 9 * div;
  endfunction

  // Output monitor: scoreboard pops, pulse counting and latency checks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && !busy_prev) detect_cyc <= cyc;
      if (fiforx_w_en) begin
        writes     <= writes + 1;
        last_w_cyc <= cyc;
        if (exp_q.size() == 0) begin
          check_eq("queue_depth", exp_q.size(), 1);
        end else begin
          check_eq("wdata", {24'd0, fiforx_w_data}, {24'd0, exp_q.pop_front()});
          check_eq("w_latency", cyc - detect_cyc, stop_lat(cur_div));
        end
      end
      if (frame_err) begin
        frame_cnt <= frame_cnt + 1;
        check_eq("frame_latency", cyc - detect_cyc, stop_lat(cur_div));
      end
      if (overrun_err) begin
        overrun_cnt <= overrun_cnt + 1;
        check_eq("overrun_latency", cyc - detect_cyc, stop_lat(cur_div));
      end
      if (rx_timeout) begin
        to_cnt      <= to_cnt + 1;
        last_to_cyc <= cyc;
      end
      busy_prev <= busy;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div);
    rx = 1'b0;
    idle(div);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(div);
    end
    rx = stop_bit;
    idle(div);
  endtask

  task automatic set_div(input int div);
    cur_div = div;
    clk_div = div;
  endtask

  initial begin
    logic [7:0] rst_byte;
    rst_byte    = 8'h81;
    rx          = 1'b1;
    fiforx_full = 1'b0;
    clk_div     = 32'd16;
    rst_n       = 1'b0;
    idle(3);
    check_eq("reset_outputs",
             {19'd0, fiforx_w_en, fiforx_w_data, frame_err, overrun_err, busy, rx_timeout}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Nominal frame at 16 clocks per bit.
    set_div(16);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 16);
    idle(10);
    check_eq("a5_writes", writes, 1);
    check_eq("a5_no_frame_err", frame_cnt, 0);
    check_eq("a5_no_overrun", overrun_cnt, 0);

    // Short low glitch: busy through the half-bit sample, then back to idle.
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3);
    check_eq("glitch_busy_in_start", busy, 1);
    idle(20);
    check_eq("glitch_busy_cleared", busy, 0);
    check_eq("glitch_no_write", writes, 1);
    check_eq("glitch_no_frame_err", frame_cnt, 0);

    // Bad stop bit, line held low afterwards.
    set_div(10);
    send_frame(8'h3C, 1'b0, 10);
    idle(30);
    check_eq("break_busy_held", busy, 1);
    check_eq("break_frame_err", frame_cnt, 1);
    check_eq("break_no_write", writes, 1);
    rx = 1'b1;
    idle(5);
    check_eq("break_busy_released", busy, 0);

    // Overrun while FIFO full, then recovery.
    set_div(16);
    fiforx_full = 1'b1;
    send_frame(8'h55, 1'b1, 16);
    fiforx_full = 1'b0;
    idle(10);
    check_eq("overrun_pulse", overrun_cnt, 1);
    check_eq("overrun_no_write", writes, 1);
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1'b1, 16);
    idle(10);
    check_eq("after_overrun_write", writes, 2);

    // Back-to-back frames with no idle gap.
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 16);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 16);
    idle(10);
    check_eq("back_to_back_writes", writes, 4);

    // Reset during data bit 4 aborts the frame.
    rx = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      rx = rst_byte[i];
      idle(16);
    end
    rx = rst_byte[4];
    idle(8);
    rst_n = 1'b0;
    #1;
    check_eq("midframe_reset_outputs",
             {19'd0, fiforx_w_en, fiforx_w_data, frame_err, overrun_err, busy, rx_timeout}, 32'd0);
    rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(5);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 16);
    idle(10);
    check_eq("after_reset_write", writes, 5);
    check_eq("scoreboard_empty", exp_q.size(), 0);
    check_eq("total_frame_err", frame_cnt, 1);
    check_eq("total_overrun", overrun_cnt, 1);

`ifdef UART_RX_TIMEOUT_EN
    // Idle timeout after one byte, firing once.
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    to_base = to_cnt;
    set_div(8);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 8);
    idle(150);
    check_eq("timeout_once", to_cnt - to_base, 1);
    check_eq("timeout_latency", last_to_cyc - last_w_cyc, 4 * 8);
    check_eq("timeout_write", exp_q.size(), 0);
`else
    check_eq("timeout_tied_low", to_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
